opll_write_sequencer: RTL and testbench

Host-side register-write sequencer that sits directly upstream of the OPLL core's CPU bus (CS_n/WR_n/A0/D). It buffers host writes in a small FIFO and replays them onto the core bus with the strobe widths and post-write wait times the YM2413 requires: 12 master clocks after an address write, 84 after a data write. The host can therefore push writes back-to-back without tracking chip timing.

---
 rtl/opll_write_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_opll_write_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opll_write_sequencer.sv
// opll_write_sequencer: buffers host writes and replays them on the OPLL
// CPU bus with YM2413 strobe/wait timing. Macro OPLL_WRSEQ_PAIR_EN: {reg,data} pairs.
module opll_write_sequencer #(
  parameter int DEPTH     = 4,
  parameter int WR_CYCLES = 2,
  parameter int ADDR_WAIT = 12,
  parameter int DATA_WAIT = 84
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic                   i_a0,
  input  logic [7:0]             i_data,
  input  logic [7:0]             i_reg,
  output logic                   o_CS_n,
  output logic                   o_WR_n,
  output logic                   o_A0,
  output logic [7:0]             o_D,
  output logic                   o_busy,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int WMAX = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
  localparam int CW   = (WMAX < 1) ? 1 : $clog2(WMAX + 1);
  localparam int SW   = $clog2(WR_CYCLES + 1);

`ifdef OPLL_WRSEQ_PAIR_EN
  localparam int EW = 16;
  logic [EW-1:0] w_wdata;
  logic          w_unused;
  assign w_wdata  = {i_reg, i_data};
  assign w_unused = i_a0;
`else
  localparam int EW = 9;
  logic [EW-1:0] w_wdata;
  logic          w_unused;
  assign w_wdata  = {i_a0, i_data};
  assign w_unused = ^i_reg;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_WAIT
  } state_t;

  state_t        r_state;
  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [SW-1:0] r_scnt;
  logic [CW-1:0] r_wcnt;

  logic          w_push;
  logic          w_pop;
  logic          w_last_half;
  logic          w_more;
  logic [AW-1:0] w_sel_ptr;
  logic [EW-1:0] w_sel;
  logic          w_sel_a0;
  logic [7:0]    w_sel_d;
  logic [CW-1:0] w_wait_n;

  assign o_ready = (r_level != LW'(DEPTH));
  assign w_push  = i_valid && o_ready;
  assign o_level = r_level;
  assign o_busy  = (r_state != S_IDLE) || (r_level != '0);

`ifdef OPLL_WRSEQ_PAIR_EN
  logic r_phase;
  assign w_last_half = r_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= 1'b0;
    end else if (r_state == S_HOLD) begin
      r_phase <= ~r_phase;
    end
  end

  // In HOLD the next SETUP shows the other half of the pair
  assign w_sel_a0 = (r_state == S_HOLD) ? ~r_phase : r_phase;
  assign w_sel_d  = w_sel_a0 ? w_sel[7:0] : w_sel[15:8];
`else
  assign w_last_half = 1'b1;
  assign w_sel_a0    = w_sel[8];
  assign w_sel_d     = w_sel[7:0];
`endif

  assign w_pop     = (r_state == S_HOLD) && w_last_half;
  assign w_more    = w_pop ? (r_level != LW'(1))
                           : (r_level != '0);
  assign w_sel_ptr = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
  assign w_sel     = r_mem[w_sel_ptr];
  assign w_wait_n  = o_A0 ? CW'(DATA_WAIT) : CW'(ADDR_WAIT);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LW'(1);
      end else if (!w_push && w_pop) begin
        r_level <= r_level - LW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_scnt  <= '0;
      r_wcnt  <= '0;
      o_CS_n  <= 1'b1;
      o_WR_n  <= 1'b1;
      o_A0    <= 1'b0;
      o_D     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_more) begin
            r_state <= S_SETUP;
            o_CS_n  <= 1'b0;
            o_A0    <= w_sel_a0;
            o_D     <= w_sel_d;
          end
        end
        S_SETUP: begin
          r_state <= S_STROBE;
          o_WR_n  <= 1'b0;
          r_scnt  <= SW'(WR_CYCLES);
        end
        S_STROBE: begin
          if (r_scnt == SW'(1)) begin
            r_state <= S_HOLD;
            o_WR_n  <= 1'b1;
          end else begin
            r_scnt <= r_scnt - SW'(1);
          end
        end
        S_HOLD: begin
          if (w_wait_n != '0) begin
            r_state <= S_WAIT;
            o_CS_n  <= 1'b1;
            r_wcnt  <= w_wait_n;
          end else if (w_more) begin
            r_state <= S_SETUP;
            o_A0    <= w_sel_a0;
            o_D     <= w_sel_d;
          end else begin
            r_state <= S_IDLE;
            o_CS_n  <= 1'b1;
            o_A0    <= 1'b0;
            o_D     <= '0;
          end
        end
        S_WAIT: begin
          if (r_wcnt != CW'(1)) begin
            r_wcnt <= r_wcnt - CW'(1);
          end else if (w_more) begin
            r_state <= S_SETUP;
            o_CS_n  <= 1'b0;
            o_A0    <= w_sel_a0;
            o_D     <= w_sel_d;
          end else begin
            r_state <= S_IDLE;
            o_A0    <= 1'b0;
            o_D     <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_opll_write_sequencer.sv
// Bench for opll_write_sequencer: vector table, hand sequences and a
// randomized run against a write-schedule reference model.
module tb_opll_write_sequencer;

  localparam int DEPTH = 4;
  localparam int WRC   = 2;
  localparam int AWT   = 12;
  localparam int DWT   = 84;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_valid = 1'b0;
  logic       i_a0 = 1'b0;
  logic [7:0] i_data = '0;
  logic [7:0] i_reg = '0;
  logic       o_ready, o_CS_n, o_WR_n, o_A0, o_busy;
  logic [7:0] o_D;
  logic [2:0] o_level;

  logic       f_valid = 1'b0;
  logic       f_a0 = 1'b0;
  logic [7:0] f_data = '0;
  logic [7:0] f_reg = '0;
  logic       f_ready, f_CS_n, f_WR_n, f_A0, f_busy;
  logic [7:0] f_D;
  logic [2:0] f_level;

  always #5 clk = ~clk;

  opll_write_sequencer u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_a0(i_a0), .i_data(i_data), .i_reg(i_reg),
    .o_CS_n(o_CS_n), .o_WR_n(o_WR_n),
    .o_A0(o_A0), .o_D(o_D),
    .o_busy(o_busy), .o_level(o_level)
  );

  opll_write_sequencer #(
    .DEPTH(4), .WR_CYCLES(1),
    .ADDR_WAIT(0), .DATA_WAIT(3)
  ) u_fast (
    .clk(clk), .rst_n(rst_n),
    .i_valid(f_valid), .o_ready(f_ready),
    .i_a0(f_a0), .i_data(f_data), .i_reg(f_reg),
    .o_CS_n(f_CS_n), .o_WR_n(f_WR_n),
    .o_A0(f_A0), .o_D(f_D),
    .o_busy(f_busy), .o_level(f_level)
  );

  typedef struct {
    int         s;
    bit         a0;
    logic [7:0] d;
  } wr_t;

  typedef struct {
    bit         a0;
    logic [7:0] d;
    logic [7:0] r;
    int         e_dly;
    bit         e_a0;
    logic [7:0] e_d;
    int         e_low;
    int         e_busy;
  } vec_t;

  int   n_checks = 0;
  int   n_fail = 0;
  int   t = 0;
  int   last_end = 0;
  wr_t  wq[$];
  int   push_t[$];
  int   pop_t[$];
  int   seen_s[$];
  logic prev_cs = 1'b1;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d: got %0h expected %0h", nm, t, act, exp);
    end
  endtask

  function automatic int m_level();
    int n;
    n = push_t.size();
    foreach (pop_t[i]) if (pop_t[i] <= t) n--;
    return n;
  endfunction

  // Each accepted entry gets its bus slot(s) scheduled from plain timing rules
  function automatic void m_push(bit a0, logic [7:0] d, logic [7:0] r);
    int s;
    s = (t + 1 > last_end) ? t + 1 : last_end;
    push_t.push_back(t);
`ifdef OPLL_WRSEQ_PAIR_EN
    wq.push_back('{s, 1'b0, r});
    s = s + 2 + WRC + AWT;
    wq.push_back('{s, 1'b1, d});
    pop_t.push_back(s + 2 + WRC);
    last_end = s + 2 + WRC + DWT;
`else
    wq.push_back('{s, a0, d});
    pop_t.push_back(s + 2 + WRC);
    last_end = s + 2 + WRC + (a0 ? DWT : AWT);
`endif
  endfunction

  function automatic void m_reset();
    wq.delete();
    push_t.delete();
    pop_t.delete();
    last_end = 0;
  endfunction

  task automatic m_check();
    int         lvl, r, wt;
    bit         cs, wr, a0, idle;
    logic [7:0] d;
    lvl = m_level();
    cs = 1; wr = 1; a0 = 0; d = '0; idle = 1;
    for (int i = wq.size() - 1; i >= 0; i--) begin
      if (wq[i].s <= t) begin
        r  = t - wq[i].s;
        wt = wq[i].a0 ? DWT : AWT;
        if (r <= WRC + 1) begin
          idle = 0; cs = 0;
          wr = !(r >= 1 && r <= WRC);
          a0 = wq[i].a0; d = wq[i].d;
        end else if (r < WRC + 2 + wt) begin
          idle = 0;
          a0 = wq[i].a0; d = wq[i].d;
        end
        break;
      end
    end
    check("cs_n", o_CS_n, cs);
    check("wr_n", o_WR_n, wr);
    check("a0", o_A0, a0);
    check("d", o_D, d);
    check("busy", o_busy, !idle || lvl != 0);
    check("level", o_level, lvl);
    check("ready", o_ready, lvl != DEPTH);
  endtask

  task automatic tick(input bit v, input bit a0, input logic [7:0] d,
                      input logic [7:0] r, output bit acc);
    i_valid = v; i_a0 = a0; i_data = d; i_reg = r;
    acc = v && (m_level() != DEPTH);
    @(posedge clk);
    t++;
    if (acc) m_push(a0, d, r);
    #1;
    i_valid = 1'b0;
    if (prev_cs === 1'b1 && o_CS_n === 1'b0) seen_s.push_back(t);
    prev_cs = o_CS_n;
    m_check();
  endtask

  task automatic tick0();
    bit acc;
    tick(0, 0, 8'h00, 8'h00, acc);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (o_busy !== 1'b0 && n < 400) begin
      tick0();
      n++;
    end
    check("idle_timeout", n < 400, 1);
  endtask

  vec_t tbl[4];
  int   lows_t[$];
  int   lows_d[$];

  initial begin
    bit acc;
    int k, bcnt, first, lows, pushed, peak, n;
    bit fa0, done;
    logic [7:0] fd;

`ifdef OPLL_WRSEQ_PAIR_EN
    tbl[0] = '{0, 8'hAB, 8'h10, 1, 0, 8'h10, 4, 105};
    tbl[1] = '{1, 8'h55, 8'h20, 1, 0, 8'h20, 4, 105};
    tbl[2] = '{0, 8'hFF, 8'h3F, 1, 0, 8'h3F, 4, 105};
    tbl[3] = '{1, 8'h00, 8'h0E, 1, 0, 8'h0E, 4, 105};
`else
    tbl[0] = '{0, 8'h30, 8'h00, 1, 0, 8'h30, 2, 17};
    tbl[1] = '{1, 8'h55, 8'h11, 1, 1, 8'h55, 2, 89};
    tbl[2] = '{0, 8'hFF, 8'hA5, 1, 0, 8'hFF, 2, 17};
    tbl[3] = '{1, 8'h00, 8'h3C, 1, 1, 8'h00, 2, 89};
`endif

    repeat (3) @(posedge clk);
    #1;
    check("rst_cs", o_CS_n, 1);
    check("rst_wr", o_WR_n, 1);
    check("rst_a0", o_A0, 0);
    check("rst_d", o_D, 0);
    check("rst_level", o_level, 0);
    check("rst_ready", o_ready, 1);
    check("rst_busy", o_busy, 0);
    rst_n = 1'b1;

    for (int v = 0; v < 4; v++) begin
      wait_idle();
      tick(1, tbl[v].a0, tbl[v].d, tbl[v].r, acc);
      k = t; bcnt = 0; first = -1; lows = 0; done = 0;
      fa0 = 0; fd = '0;
      for (int c = 0; c < 300 && !done; c++) begin
        if (o_busy !== 1'b1) begin
          done = 1;
        end else begin
          bcnt++;
          if (first < 0 && o_CS_n === 1'b0) begin
            first = t - k; fa0 = o_A0; fd = o_D;
          end
          if (o_WR_n === 1'b0) lows++;
          tick0();
        end
      end
      check("vec_done", done, 1);
      check("vec_setup_dly", first, tbl[v].e_dly);
      check("vec_a0", fa0, tbl[v].e_a0);
      check("vec_d", fd, tbl[v].e_d);
      check("vec_wr_low", lows, tbl[v].e_low);
      check("vec_busy_len", bcnt, tbl[v].e_busy);
    end

    wait_idle();
    seen_s.delete();
    tick(1, 1, 8'h55, 8'h40, acc);
    tick(1, 0, 8'h10, 8'h41, acc);
    n = 0;
    while (seen_s.size() < 2 && n < 300) begin
      tick0();
      n++;
    end
    check("period_seen", seen_s.size() >= 2, 1);
`ifdef OPLL_WRSEQ_PAIR_EN
    if (seen_s.size() >= 2) check("period", seen_s[1] - seen_s[0], 16);
`else
    if (seen_s.size() >= 2) check("period", seen_s[1] - seen_s[0], 88);
`endif

    wait_idle();
    seen_s.delete();
    pushed = 0; peak = 0; n = 0;
    while (pushed < DEPTH + 1 && n < 400) begin
      tick(1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), acc);
      if (acc) begin
        pushed++;
        if (pushed == DEPTH) check("full_ready", o_ready, 0);
      end
      if (int'(o_level) > peak) peak = int'(o_level);
      n++;
    end
    check("burst_pushed", pushed, DEPTH + 1);
    wait_idle();
    check("burst_peak", peak, DEPTH);
`ifdef OPLL_WRSEQ_PAIR_EN
    check("burst_writes", seen_s.size(), 2 * (DEPTH + 1));
`else
    check("burst_writes", seen_s.size(), DEPTH + 1);
`endif

    tick(1, 0, 8'h30, 8'h07, acc);
    n = 0;
    while (o_WR_n !== 1'b0 && n < 10) begin
      tick0();
      n++;
    end
    check("strobe_reached", o_WR_n, 0);
    #1 rst_n = 1'b0;
    #1;
    check("amid_cs", o_CS_n, 1);
    check("amid_wr", o_WR_n, 1);
    check("amid_level", o_level, 0);
    check("amid_ready", o_ready, 1);
    m_reset();
    prev_cs = 1'b1;
    #1 rst_n = 1'b1;
    repeat (20) tick0();

    for (int c = 0; c < 2500; c++) begin
      tick($urandom_range(0, 11) == 0, 1'($urandom_range(0, 1)),
           8'($urandom), 8'($urandom), acc);
    end
    wait_idle();

`ifndef OPLL_WRSEQ_PAIR_EN
    k = 0;
    for (int c = 0; c < 16; c++) begin
      f_valid = (c < 3);
      f_a0 = 1'b0;
      f_data = 8'(c + 1);
      tick0();
      f_valid = 1'b0;
      if (c == 0) k = t;
      if (f_WR_n === 1'b0) begin
        lows_t.push_back(t);
        lows_d.push_back(int'(f_D));
      end
    end
    check("fast_lows", lows_t.size(), 3);
    if (lows_t.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check("fast_low_t", lows_t[i] - k, 2 + 3 * i);
        check("fast_low_d", lows_d[i], i + 1);
      end
    end
    check("fast_idle_cs", f_CS_n, 1);
    check("fast_idle_busy", f_busy, 0);
    check("fast_idle_lvl", f_level, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
